// File: rtl/iomem_timer.sv
// Memory-mapped down-counting timer on the SoC iomem bus.
// Prescaled tick decrements COUNT; expiry raises PEND and optionally reloads from LOAD.
module iomem_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h0300_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic        irq
);
    localparam int unsigned DW = 32;
    localparam int unsigned PW = 16;

    localparam logic [2:0] REG_CTRL     = 3'd0;
    localparam logic [2:0] REG_PRESCALE = 3'd1;
    localparam logic [2:0] REG_LOAD     = 3'd2;
    localparam logic [2:0] REG_COUNT    = 3'd3;
    localparam logic [2:0] REG_STATUS   = 3'd4;

    logic          en, ie, reload, pend;
    logic [PW-1:0] prescale, pre_cnt;
    logic [DW-1:0] load, count;

    logic          en_nxt, ie_nxt, reload_nxt, pend_nxt;
    logic [PW-1:0] prescale_nxt, pre_cnt_nxt;
    logic [DW-1:0] load_nxt, count_nxt;

    logic          sel_c, acc_c, wr_c, tick_c, stop_c;
    logic          wr_ctrl_c, wr_prescale_c, wr_load_c, w1c_c;
    logic [2:0]    reg_idx_c;
    logic [DW-1:0] old_c, merged_c, rd_mux_c;
    logic          unused_addr_c;

    // Bus decode: one ack per select, never on the cycle right after an ack
    assign sel_c         = iomem_valid && (iomem_addr[31:5] == BASE_ADDR[31:5]);
    assign acc_c         = sel_c && !iomem_ready;
    assign wr_c          = acc_c && (iomem_wstrb != 4'd0);
    assign reg_idx_c     = iomem_addr[4:2];
    assign unused_addr_c = ^iomem_addr[1:0];

    assign wr_ctrl_c     = wr_c && (reg_idx_c == REG_CTRL) && iomem_wstrb[0];
    assign wr_prescale_c = wr_c && (reg_idx_c == REG_PRESCALE);
    assign wr_load_c     = wr_c && (reg_idx_c == REG_LOAD);
    assign w1c_c         = wr_c && (reg_idx_c == REG_STATUS) && iomem_wstrb[0] && iomem_wdata[0];

    // A CTRL write that leaves EN low freezes the counter on that very edge
    assign stop_c = wr_ctrl_c && !iomem_wdata[0];
    assign tick_c = en && !stop_c && (pre_cnt == prescale);

    assign irq = pend && ie;

    // Byte-strobe merge against the addressed writable register
    always_comb begin
        old_c = (reg_idx_c == REG_PRESCALE) ? {16'd0, prescale} : load;
        for (int i = 0; i < 4; i++) begin
            merged_c[8*i +: 8] = iomem_wstrb[i] ? iomem_wdata[8*i +: 8] : old_c[8*i +: 8];
        end
    end

    always_comb begin
        rd_mux_c = '0;
        case (reg_idx_c)
            REG_CTRL:     rd_mux_c = {29'd0, reload, ie, en};
            REG_PRESCALE: rd_mux_c = {16'd0, prescale};
            REG_LOAD:     rd_mux_c = load;
            REG_COUNT:    rd_mux_c = count;
            REG_STATUS:   rd_mux_c = {31'd0, pend};
            default:      rd_mux_c = '0;
        endcase
    end

    // Next state: W1C first so expiry set wins, bus writes last so they override ticks
    always_comb begin
        en_nxt       = en;
        ie_nxt       = ie;
        reload_nxt   = reload;
        pend_nxt     = pend;
        prescale_nxt = prescale;
        load_nxt     = load;
        count_nxt    = count;
        pre_cnt_nxt  = pre_cnt;

        if (w1c_c) begin
            pend_nxt = 1'b0;
        end

        if (tick_c) begin
            pre_cnt_nxt = '0;
            if (count != '0) begin
                count_nxt = count - DW'(1);
            end else begin
                pend_nxt = 1'b1;
                if (reload) begin
                    count_nxt = load;
                end else begin
                    en_nxt = 1'b0;
                end
            end
        end else if (en) begin
            pre_cnt_nxt = pre_cnt + PW'(1);
        end

        if (wr_ctrl_c) begin
            en_nxt     = iomem_wdata[0];
            ie_nxt     = iomem_wdata[1];
            reload_nxt = iomem_wdata[2];
            if (stop_c) begin
                pre_cnt_nxt = '0;
            end
        end

        if (wr_prescale_c) begin
            prescale_nxt = merged_c[PW-1:0];
        end

        if (wr_load_c) begin
            load_nxt    = merged_c;
            count_nxt   = merged_c;
            pre_cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en          <= 1'b0;
            ie          <= 1'b0;
            reload      <= 1'b0;
            pend        <= 1'b0;
            prescale    <= '0;
            pre_cnt     <= '0;
            load        <= '0;
            count       <= '0;
            iomem_ready <= 1'b0;
            iomem_rdata <= '0;
        end else begin
            en          <= en_nxt;
            ie          <= ie_nxt;
            reload      <= reload_nxt;
            pend        <= pend_nxt;
            prescale    <= prescale_nxt;
            pre_cnt     <= pre_cnt_nxt;
            load        <= load_nxt;
            count       <= count_nxt;
            iomem_ready <= acc_c;
            iomem_rdata <= acc_c ? rd_mux_c : '0;
        end
    end

endmodule

// File: tb/tb_iomem_timer.sv
// Self-checking bench for iomem_timer: scoreboarded register reads plus cycle-exact timer checks.
module tb_iomem_timer;
    localparam logic [31:0] BASE = 32'h0300_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        iomem_valid = 1'b0;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb = 4'h0;
    logic [31:0] iomem_addr = 32'h0;
    logic [31:0] iomem_wdata = 32'h0;
    logic [31:0] iomem_rdata;
    logic        irq;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    logic [31:0] exp_q[$];
    logic [31:0] exp;
    logic        last_ok, last_rdy_after;
    logic [31:0] last_rd;
    int          last_cyc, last_lat;
    int          e0;

    iomem_timer #(.BASE_ADDR(BASE)) dut (
        .clk(clk),
        .reset(reset),
        .iomem_valid(iomem_valid),
        .iomem_ready(iomem_ready),
        .iomem_wstrb(iomem_wstrb),
        .iomem_addr(iomem_addr),
        .iomem_wdata(iomem_wdata),
        .iomem_rdata(iomem_rdata),
        .irq(irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Bus master: holds valid until ack (bounded), records commit cycle, idles one cycle
    task automatic acc(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        int vcyc;
        last_ok = 1'b0; last_rd = '0; last_cyc = 0; last_lat = 0;
        @(negedge clk);
        iomem_valid = 1'b1; iomem_addr = a; iomem_wstrb = s; iomem_wdata = d;
        vcyc = cyc;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (iomem_ready === 1'b1) begin
                last_ok = 1'b1; last_rd = iomem_rdata; last_cyc = cyc; last_lat = cyc - vcyc;
                break;
            end
        end
        iomem_valid = 1'b0; iomem_wstrb = 4'h0; iomem_addr = 32'h0; iomem_wdata = 32'h0;
        @(posedge clk); #1;
        last_rdy_after = iomem_ready;
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 1'b1;
        @(negedge clk); @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (iomem_ready !== 1'b0 || iomem_rdata !== 32'h0 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs ready=%b rdata=%h irq=%b expected 0/0/0", iomem_ready, iomem_rdata, irq);
        end
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_read_ctrl();
        exp_q.push_back(32'h0);
        acc(BASE, 4'h0, 32'h0);
        exp = exp_q.pop_front();
        n_checks++;
        if (!last_ok || last_rd !== exp || last_lat != 1 || last_rdy_after !== 1'b0) begin
            n_fail++;
            $display("FAIL read_ctrl ok=%b rdata=%h lat=%0d ready_after=%b expected 1/%h/1/0",
                     last_ok, last_rd, last_lat, last_rdy_after, exp);
        end
        for (int off = 4; off <= 16; off += 4) begin
            exp_q.push_back(32'h0);
            acc(BASE + 32'(off), 4'h0, 32'h0);
            exp = exp_q.pop_front();
            n_checks++;
            if (!last_ok || last_rd !== exp) begin
                n_fail++;
                $display("FAIL reset_reg off=%0h ok=%b got=%h exp=%h", off, last_ok, last_rd, exp);
            end
        end
    endtask

    task automatic test_regs();
        acc(BASE + 32'h0, 4'hF, 32'hFFFF_FFF8);
        exp_q.push_back(32'h0);
        acc(BASE + 32'h0, 4'h0, 32'h0);
        exp = exp_q.pop_front(); n_checks++;
        if (!last_ok || last_rd !== exp) begin
            n_fail++; $display("FAIL ctrl_upper got=%h exp=%h", last_rd, exp);
        end
        acc(BASE + 32'h0, 4'hF, 32'h0000_0006);
        acc(BASE + 32'h4, 4'hF, 32'hFFFF_1234);
        acc(BASE + 32'h8, 4'hF, 32'hDEAD_BEEF);
        acc(BASE + 32'hC, 4'hF, 32'h0000_0005);
        exp_q.push_back(32'h6); exp_q.push_back(32'h1234);
        exp_q.push_back(32'hDEAD_BEEF); exp_q.push_back(32'hDEAD_BEEF);
        for (int off = 0; off <= 12; off += 4) begin
            acc(BASE + 32'(off), 4'h0, 32'h0);
            exp = exp_q.pop_front(); n_checks++;
            if (!last_ok || last_rd !== exp) begin
                n_fail++; $display("FAIL regs off=%0h ok=%b got=%h exp=%h", off, last_ok, last_rd, exp);
            end
        end
        // A write transaction returns the value from before the write
        exp_q.push_back(32'hDEAD_BEEF);
        acc(BASE + 32'h8, 4'hF, 32'h0000_0001);
        exp = exp_q.pop_front(); n_checks++;
        if (!last_ok || last_rd !== exp) begin
            n_fail++; $display("FAIL write_prev_rdata got=%h exp=%h", last_rd, exp);
        end
        acc(BASE + 32'h14, 4'hF, 32'hFFFF_FFFF);
        n_checks++;
        if (last_ok !== 1'b1 || last_rd !== 32'h0) begin
            n_fail++; $display("FAIL reserved_write ok=%b rdata=%h expected 1/0", last_ok, last_rd);
        end
        exp_q.push_back(32'h0);
        acc(BASE + 32'h1C, 4'h0, 32'h0);
        exp = exp_q.pop_front(); n_checks++;
        if (!last_ok || last_rd !== exp) begin
            n_fail++; $display("FAIL reserved_read ok=%b got=%h exp=%h", last_ok, last_rd, exp);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        iomem_valid = 1'b1; iomem_addr = BASE + 32'h4; iomem_wstrb = 4'h0;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back((i % 2 == 0) ? 32'h1234 : 32'h0);
            @(posedge clk); #1;
            exp = exp_q.pop_front(); n_checks++;
            if (iomem_ready !== 1'((i % 2) == 0) || iomem_rdata !== exp) begin
                n_fail++;
                $display("FAIL back_to_back edge=%0d ready=%b rdata=%h exp_ready=%b exp_rdata=%h",
                         i, iomem_ready, iomem_rdata, 1'((i % 2) == 0), exp);
            end
        end
        iomem_valid = 1'b0; iomem_addr = 32'h0;
        @(posedge clk); #1;
    endtask

    task automatic test_periodic();
        do_reset();
        acc(BASE + 32'h4, 4'hF, 32'h0);
        acc(BASE + 32'h8, 4'hF, 32'h4);
        acc(BASE + 32'h0, 4'hF, 32'h7);
        e0 = last_cyc;
        for (int k = cyc - e0; k <= 5; k++) begin
            n_checks++;
            if (irq !== 1'(k == 5)) begin
                n_fail++; $display("FAIL periodic_first k=%0d irq=%b exp=%b", k, irq, 1'(k == 5));
            end
            if (k < 5) begin @(posedge clk); #1; end
        end
        acc(BASE + 32'h10, 4'h1, 32'h1);
        for (int k = cyc - e0; k <= 10; k++) begin
            n_checks++;
            if (irq !== 1'(k == 10)) begin
                n_fail++; $display("FAIL periodic_second k=%0d irq=%b exp=%b", k, irq, 1'(k == 10));
            end
            if (k < 10) begin @(posedge clk); #1; end
        end
        for (int r = 0; r < 5; r++) begin
            exp_q.push_back(32'(4 - ((cyc - e0) % 5)));
            acc(BASE + 32'hC, 4'h0, 32'h0);
            exp = exp_q.pop_front(); n_checks++;
            if (!last_ok || last_rd !== exp) begin
                n_fail++; $display("FAIL periodic_count r=%0d got=%h exp=%h", r, last_rd, exp);
            end
        end
    endtask

    task automatic test_oneshot();
        do_reset();
        acc(BASE + 32'h4, 4'hF, 32'h2);
        acc(BASE + 32'h8, 4'hF, 32'h1);
        acc(BASE + 32'h0, 4'hF, 32'h3);
        e0 = last_cyc;
        for (int k = cyc - e0; k <= 6; k++) begin
            n_checks++;
            if (irq !== 1'(k == 6)) begin
                n_fail++; $display("FAIL oneshot_expiry k=%0d irq=%b exp=%b", k, irq, 1'(k == 6));
            end
            if (k < 6) begin @(posedge clk); #1; end
        end
        exp_q.push_back(32'h2); exp_q.push_back(32'h0);
        acc(BASE + 32'h0, 4'h0, 32'h0);
        exp = exp_q.pop_front(); n_checks++;
        if (!last_ok || last_rd !== exp) begin
            n_fail++; $display("FAIL oneshot_ctrl got=%h exp=%h", last_rd, exp);
        end
        acc(BASE + 32'hC, 4'h0, 32'h0);
        exp = exp_q.pop_front(); n_checks++;
        if (!last_ok || last_rd !== exp) begin
            n_fail++; $display("FAIL oneshot_count got=%h exp=%h", last_rd, exp);
        end
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (irq !== 1'b1) begin
            n_fail++; $display("FAIL oneshot_irq_hold irq=%b exp=1", irq);
        end
        acc(BASE + 32'h10, 4'hF, 32'h1);
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++; $display("FAIL oneshot_clear irq=%b exp=0", irq);
        end
    endtask

    task automatic test_w1c_race();
        do_reset();
        acc(BASE + 32'h4, 4'hF, 32'h0);
        acc(BASE + 32'h8, 4'hF, 32'h2);
        acc(BASE + 32'h0, 4'hF, 32'h7);
        e0 = last_cyc;
        acc(BASE + 32'h10, 4'h1, 32'h1);
        n_checks++;
        if (irq !== 1'b1) begin
            n_fail++; $display("FAIL race_expiry1 irq=%b exp=1", irq);
        end
        acc(BASE + 32'h10, 4'h1, 32'h1);
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++; $display("FAIL race_clear irq=%b exp=0", irq);
        end
        acc(BASE + 32'h10, 4'h1, 32'h1);
        n_checks++;
        if (irq !== 1'b1 || last_cyc - e0 != 6) begin
            n_fail++; $display("FAIL race_set_wins irq=%b commit_k=%0d exp irq=1 k=6", irq, last_cyc - e0);
        end
    endtask

    task automatic test_byte_write();
        do_reset();
        acc(BASE + 32'h8, 4'hF, 32'h1122_3344);
        acc(BASE + 32'h8, 4'b0010, 32'h0000_AB00);
        exp_q.push_back(32'h1122_AB44); exp_q.push_back(32'h1122_AB44);
        for (int off = 8; off <= 12; off += 4) begin
            acc(BASE + 32'(off), 4'h0, 32'h0);
            exp = exp_q.pop_front(); n_checks++;
            if (!last_ok || last_rd !== exp) begin
                n_fail++; $display("FAIL byte_write off=%0h got=%h exp=%h", off, last_rd, exp);
            end
        end
        // Mid-prescale LOAD write must restart the prescaler from zero
        acc(BASE + 32'h4, 4'hF, 32'h3);
        acc(BASE + 32'h8, 4'hF, 32'h5);
        acc(BASE + 32'h0, 4'hF, 32'h3);
        repeat (3) @(posedge clk);
        #1;
        acc(BASE + 32'h8, 4'b0001, 32'h0000_0002);
        e0 = last_cyc;
        for (int k = cyc - e0; k <= 12; k++) begin
            n_checks++;
            if (irq !== 1'(k == 12)) begin
                n_fail++; $display("FAIL load_restart k=%0d irq=%b exp=%b", k, irq, 1'(k == 12));
            end
            if (k < 12) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_unselected();
        do_reset();
        acc(BASE + 32'h8, 4'hF, 32'hA5A5_A5A5);
        acc(BASE + 32'h20, 4'hF, 32'hFFFF_FFFF);
        n_checks++;
        if (last_ok !== 1'b0) begin
            n_fail++; $display("FAIL unsel_0x20 ready=%b exp=0", last_ok);
        end
        acc(32'h0200_0008, 4'hF, 32'h0000_0000);
        n_checks++;
        if (last_ok !== 1'b0) begin
            n_fail++; $display("FAIL unsel_other ready=%b exp=0", last_ok);
        end
        exp_q.push_back(32'hA5A5_A5A5);
        acc(BASE + 32'h8, 4'h0, 32'h0);
        exp = exp_q.pop_front(); n_checks++;
        if (!last_ok || last_rd !== exp) begin
            n_fail++; $display("FAIL unsel_load got=%h exp=%h", last_rd, exp);
        end
    endtask

    task automatic test_reset_abort();
        do_reset();
        acc(BASE + 32'h4, 4'hF, 32'h0);
        acc(BASE + 32'h8, 4'hF, 32'h0);
        acc(BASE + 32'h0, 4'hF, 32'h7);
        @(negedge clk);
        iomem_valid = 1'b1; iomem_addr = BASE; iomem_wstrb = 4'h0;
        @(posedge clk); #1;
        n_checks++;
        if (iomem_ready !== 1'b1 || iomem_rdata !== 32'h7 || irq !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset ready=%b rdata=%h irq=%b expected 1/7/1", iomem_ready, iomem_rdata, irq);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (iomem_ready !== 1'b0 || iomem_rdata !== 32'h0 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset ready=%b rdata=%h irq=%b expected 0/0/0", iomem_ready, iomem_rdata, irq);
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (iomem_ready !== 1'b0) begin
                n_fail++; $display("FAIL reset_no_ack edge=%0d ready=%b exp=0", i, iomem_ready);
            end
        end
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (iomem_ready !== 1'b1 || iomem_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL post_reset_ack ready=%b rdata=%h expected 1/0", iomem_ready, iomem_rdata);
        end
        iomem_valid = 1'b0; iomem_addr = 32'h0;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_read_ctrl();
        test_regs();
        test_back_to_back();
        test_periodic();
        test_oneshot();
        test_w1c_race();
        test_byte_write();
        test_unselected();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/iomem_timer.md
IOMEM_TIMER -- requirements
Module: iomem_timer

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0300_0000, base of the 32-byte register window; BASE_ADDR[4:0] SHALL be 0.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; all state SHALL clear immediately on assertion.
REQ-004 iomem_valid  input  1  bus request from SoC iomem port.
REQ-005 iomem_ready  output  1  registered acknowledge.
REQ-006 iomem_wstrb  input  4  byte write strobes; 0 = read.
REQ-007 iomem_addr  input  32  byte address.
REQ-008 iomem_wdata  input  32  write data.
REQ-009 iomem_rdata  output  32  registered read data, valid while iomem_ready=1.
REQ-010 irq  output  1  level interrupt to SoC irq_5 input.

Function
REQ-011 Select SHALL be iomem_valid && iomem_addr[31:5]==BASE_ADDR[31:5]; non-selected requests SHALL cause no state change and no ready.
REQ-012 Registers at word offsets: 0x00 CTRL (bit0 EN, bit1 IE, bit2 RELOAD; other bits read 0), 0x04 PRESCALE (16-bit, upper bits read 0), 0x08 LOAD (32-bit), 0x0C COUNT (32-bit, read-only), 0x10 STATUS (bit0 PEND, write-1-to-clear); offsets 0x14-0x1C read 0, writes ignored, still acknowledged.
REQ-013 Handshake: on an edge with select && !iomem_ready, iomem_ready SHALL be set to 1 and iomem_rdata loaded; next edge iomem_ready SHALL return to 0; latency exactly 1 cycle, at most one ack per two cycles.
REQ-014 Writes SHALL commit on the same edge that sets iomem_ready, honouring iomem_wstrb per byte; reads SHALL return pre-write register values.
REQ-015 iomem_rdata SHALL be 0 on any edge where iomem_ready is not being set.
REQ-016 Prescaler: 16-bit pre_cnt increments each cycle while EN=1; when pre_cnt==PRESCALE a tick SHALL occur and pre_cnt SHALL return to 0; PRESCALE=0 ticks every cycle.
REQ-017 On tick with COUNT!=0: COUNT SHALL decrement by 1.
REQ-018 On tick with COUNT==0 (expiry): PEND SHALL set; if RELOAD=1 COUNT SHALL load LOAD and EN stays 1; if RELOAD=0 EN SHALL clear and COUNT stays 0.
REQ-019 Period between expiries with RELOAD=1 SHALL be (LOAD+1)*(PRESCALE+1) cycles.
REQ-020 Any write touching LOAD SHALL also copy the new LOAD value into COUNT and clear pre_cnt; this overrides a same-cycle tick.
REQ-021 Write to CTRL leaving EN=0 SHALL freeze COUNT and clear pre_cnt; setting EN 0->1 SHALL start counting on the next cycle.
REQ-022 PEND set by expiry and W1C clear on the same edge: set SHALL win.
REQ-023 irq SHALL equal PEND && IE combinationally from registered state; no other path.
REQ-024 COUNT decrement SHALL never wrap below 0.

Reset
REQ-025 While reset=1: CTRL, PRESCALE, LOAD, COUNT, PEND, pre_cnt, iomem_ready, iomem_rdata, irq SHALL all be 0.
REQ-026 Reset asserted mid-transaction SHALL abort it without ack; after release first ack SHALL be 1 cycle after next select.

Verification
REQ-027 Read CTRL after reset -> ready 1 cycle after valid, rdata=0x0, ready low next cycle.
REQ-028 PRESCALE=0, LOAD=4, CTRL=0x7 -> PEND and irq=1 5 cycles after EN, then every 5 cycles; COUNT reads 4,3,2,1,0 sequence.
REQ-029 PRESCALE=2, LOAD=1, CTRL=0x3 (one-shot) -> single expiry after 6 cycles, EN reads 0, COUNT=0, irq stays 1 until STATUS write 0x1.
REQ-030 Write STATUS=0x1 on expiry edge -> PEND remains 1.
REQ-031 Byte write wstrb=4'b0010 data 0x0000_AB00 to LOAD=0x11223344 -> LOAD and COUNT = 0x1122AB44, pre_cnt=0.
REQ-032 Access to BASE_ADDR+0x20 -> no ready, no register change; reset pulse during counting -> all outputs 0 immediately.
